// File: rtl/expr_string_gen_if.sv
// Byte-stream handshake between the expression generator and its consumer.
interface expr_string_gen_if;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;
   logic       out_last;

   modport master (output out_valid, output out_char, output out_last, input out_ready);
   modport slave  (input out_valid, input out_char, input out_last, output out_ready);
endinterface

// File: rtl/expr_string_gen.sv
// Buffers up to DEPTH terms and serializes them as "d(op d)*" ASCII bytes
// over a valid/ready stream with a last-byte flag and a completion pulse.
module expr_string_gen #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [3:0]        wr_digit,
   input  logic              wr_op,
   output logic              full,
   output logic [ADDR_W:0]   count,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   expr_string_gen_if.master ob
);

   typedef enum logic [1:0] {IDLE, DIG, OP, FIN} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_t              state_r, state_nxt_s;
   logic [ADDR_W-1:0]   idx_r, idx_nxt_s, idx_inc_s;
   logic [ADDR_W:0]     count_r, count_nxt_s;
   logic                full_r, full_nxt_s;
   logic                valid_r, valid_nxt_s;
   logic [7:0]          char_r, char_nxt_s;
   logic                last_r, last_nxt_s;
   logic                done_r, done_nxt_s;
   logic                busy_r, busy_nxt_s;
   logic                err_r, err_nxt_s;
   logic [3:0]          digit_r [DEPTH];
   logic [DEPTH-1:0]    op_r;
   logic                xfer_s, start_ok_s, wr_try_s, wr_ok_s, wr_bad_s;

   assign xfer_s     = valid_r && ob.out_ready;
   assign start_ok_s = (state_r == IDLE) && start && (count_r != '0);
   // A write only competes with start when the start is actually taken
   assign wr_try_s   = (state_r == IDLE) && wr_en && !start_ok_s && !full_r;
   assign wr_ok_s    = wr_try_s && (wr_digit <= 4'd9);
   assign wr_bad_s   = wr_try_s && (wr_digit > 4'd9);
   assign idx_inc_s  = idx_r + ADDR_W'(1);

   // Next-state and next-output computation
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      count_nxt_s = count_r;
      valid_nxt_s = valid_r;
      char_nxt_s  = char_r;
      last_nxt_s  = last_r;
      done_nxt_s  = 1'b0;
      busy_nxt_s  = busy_r;
      err_nxt_s   = err_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               state_nxt_s = DIG;
               idx_nxt_s   = '0;
               valid_nxt_s = 1'b1;
               char_nxt_s  = 8'd48 + {4'd0, digit_r[0]};
               last_nxt_s  = (count_r == ONE_C);
               busy_nxt_s  = 1'b1;
               err_nxt_s   = 1'b0;
            end else if (wr_ok_s) begin
               count_nxt_s = count_r + ONE_C;
            end else if (wr_bad_s) begin
               err_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DIG: begin
            if (xfer_s && last_r) begin
               state_nxt_s = FIN;
               valid_nxt_s = 1'b0;
               char_nxt_s  = 8'd0;
               last_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
               busy_nxt_s  = 1'b0;
               count_nxt_s = '0;
            end else if (xfer_s) begin
               state_nxt_s = OP;
               char_nxt_s  = op_r[idx_inc_s] ? 8'd42 : 8'd43;
               last_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = DIG;
            end
         end
         OP: begin
            if (xfer_s) begin
               state_nxt_s = DIG;
               idx_nxt_s   = idx_inc_s;
               char_nxt_s  = 8'd48 + {4'd0, digit_r[idx_inc_s]};
               last_nxt_s  = ({1'b0, idx_inc_s} == (count_r - ONE_C));
            end else begin
               state_nxt_s = OP;
            end
         end
         FIN: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
         end
      endcase
      full_nxt_s = (count_nxt_s == DEPTH_C);
   end

   // State and registered outputs, cleared synchronously by clr
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r <= IDLE;
         idx_r   <= '0;
         count_r <= '0;
         full_r  <= 1'b0;
         valid_r <= 1'b0;
         char_r  <= 8'd0;
         last_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         count_r <= count_nxt_s;
         full_r  <= full_nxt_s;
         valid_r <= valid_nxt_s;
         char_r  <= char_nxt_s;
         last_r  <= last_nxt_s;
         done_r  <= done_nxt_s;
         busy_r  <= busy_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // Term storage; emptiness is tracked by count_r alone
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         digit_r[count_r[ADDR_W-1:0]] <= wr_digit;
         op_r[count_r[ADDR_W-1:0]]    <= wr_op;
      end
   end

   assign full         = full_r;
   assign count        = count_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign err          = err_r;
   assign ob.out_valid = valid_r;
   assign ob.out_char  = char_r;
   assign ob.out_last  = last_r;

endmodule

// File: doc/expr_string_gen.md
Name: expr_string_gen

Overview:
- Transmit-side counterpart of the expression-string checker. Emits ASCII strings of the form digit (op digit)*, with op being '+' (43) or '*' (42), one byte per handshake.
- The host loads up to DEPTH terms into an internal buffer and pulses start. The block then serializes the terms as a byte stream with a valid/ready handshake and a last-byte flag.
- Its output feeds the checker directly or any byte-wide consumer.

Parameters:
DEPTH, 8, number of term entries in the buffer (power of 2, ≥2)
ADDR_W, 3, log2(DEPTH); width of buffer index

Ports:
clk  input  1  rising-edge clock
clr  input  1  reset, synchronous, active-high
wr_en  input  1  write one term into the buffer
wr_digit  input  4  term value, legal range 0..9
wr_op  input  1  operator preceding this term: 0 = '+', 1 = '*'; ignored for the first term
full  output  1  buffer holds DEPTH terms
count  output  ADDR_W+1  number of terms currently buffered
start  input  1  begin emitting the buffered expression
busy  output  1  emission in progress
out_valid  output  1  out_char is valid
out_ready  input  1  consumer accepts the byte this cycle
out_char  output  8  ASCII byte
out_last  output  1  marks the final byte of the expression
done  output  1  one-cycle pulse after the final byte is accepted
err  output  1  sticky: an illegal term write was rejected

Behaviour:
- Reset: clr is sampled on posedge clk only. All outputs and state clear: out_valid=0, out_char=0, out_last=0, done=0, busy=0, err=0, count=0, state=IDLE. The buffer is logically emptied.
- clr mid-emission aborts immediately. The next cycle shows out_valid=0, and no done pulse is produced.
- Writes:
  - Accepted only when wr_en=1, busy=0, full=0 and wr_digit≤9. The entry is stored at index count and count increments.
  - wr_digit>9: the write is dropped and err is set.
  - Write while full or busy: dropped silently, err unchanged.
  - err clears only on clr or on an accepted start.
- Start:
  - start=1 with busy=0 and count>0 begins emission: busy=1, state DIG, index i=0.
  - start while busy, or with count==0, is ignored.
  - wr_en and start in the same cycle: start wins and the write is dropped.
- States:
  - IDLE, DIG, OP, FIN.
  - All outputs are registered. The first byte appears with out_valid=1 on the cycle after start is sampled.
- DIG:
  - out_char = 8'd48 + digit[i].
  - out_last = 1 iff i == count-1.
- OP:
  - out_char = 8'd42 if op[i+1]=1, else 8'd43.
  - out_last = 0.
- Handshake:
  - A byte transfers on a cycle with out_valid && out_ready.
  - While out_valid && !out_ready, out_char and out_last hold stable.
  - out_valid never drops without a transfer, except on clr.
  - With out_ready held high, the block sustains one byte per cycle with no bubbles between bytes.
- Transitions on transfer:
  - DIG, not last → OP.
  - OP → DIG with i = i+1.
  - DIG, last → FIN.
- FIN (one cycle):
  - out_valid=0, done=1, busy=0, count cleared to 0; then IDLE.
  - A start during FIN is ignored. New writes are accepted from IDLE onward.
- Stream length: 2*count−1 bytes. Every emitted string is accepted by the checker (out high after each digit byte).

Test Plan:
- Write (3,-),(5,'+'),(7,'*'), start, out_ready=1 → bytes 0x33,0x2B,0x35,0x2A,0x37 on 5 consecutive cycles; out_last only on 0x37; done pulses the next cycle; count returns to 0.
- Single term (9), start → one byte 0x39 with out_last=1, then done; an immediate second start with count==0 produces no output.
- Backpressure: 2 terms (1,'*'2), out_ready toggled 1,0,0,1,1 → out_char holds 0x2A through the stalled cycles; sequence 0x31,0x2A,0x32 is delivered exactly once each.
- Fill: 9 writes of digit 4 → count=8, full=1, 9th dropped, err=0; emission produces 15 bytes alternating 0x34 and the operator bytes.
- Illegal write wr_digit=12 → count unchanged, err=1 held; err clears on the next accepted start.
- clr asserted after the 2nd byte of "3+5*7" → next cycle out_valid=0, busy=0, count=0, no done pulse; a fresh load and start emits correctly.
